// File: rtl/lc3b_types.sv
// Shared types for the L1 cache responder: tag/index/offset/line types,
// the controller state enum and a byte-lane merge helper.
package lc3b_types;

  localparam int C_NUM_SETS = 8;
  localparam int C_TAG_W    = 9;
  localparam int C_INDEX_W  = $clog2(C_NUM_SETS);

  typedef logic [C_TAG_W-1:0]   lc3b_c_tag;
  typedef logic [C_INDEX_W-1:0] lc3b_c_index;
  typedef logic [2:0]           lc3b_c_offset;
  typedef logic [127:0]         lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } lc3b_cache_state;

  // Replace only the byte lanes selected by be; be=2'b00 leaves the word untouched.
  function automatic logic [15:0] merge_word(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  be);
    logic [15:0] res;
    res[7:0]  = be[0] ? new_w[7:0]  : old_w[7:0];
    res[15:8] = be[1] ? new_w[15:8] : old_w[15:8];
    return res;
  endfunction

endpackage

// File: rtl/l1_cache_control.sv
// Miss-handling controller for the L1 cache responder. Sequences the
// IDLE -> (WRITEBACK ->) FILL -> IDLE miss path and drives the pmem
// handshake from registers so address/data stay stable until pmem_resp.
module l1_cache_control
  import lc3b_types::*;
#(
  parameter int TAG_W = C_TAG_W,
  parameter int IDX_W = C_INDEX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             hit_i,
  input  logic             victim_dirty_i,
  input  logic [TAG_W-1:0] victim_tag_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [IDX_W-1:0] index_i,
  input  lc3b_c_block      victim_line_i,
  input  logic             pmem_resp_i,
  output logic             idle_o,
  output logic             load_line_o,
  output logic             pmem_read_o,
  output logic             pmem_write_o,
  output logic [15:0]      pmem_address_o,
  output lc3b_c_block      pmem_wdata_o
);

  lc3b_cache_state state_q;
  logic            pmem_read_q;
  logic            pmem_write_q;
  logic [15:0]     pmem_address_q;
  lc3b_c_block     pmem_wdata_q;

  // Miss FSM; pmem outputs are registered alongside the state transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 16'h0000;
      pmem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && !hit_i) begin
            if (victim_dirty_i) begin
              state_q        <= WRITEBACK;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {victim_tag_i, index_i, 4'b0000};
              pmem_wdata_q   <= victim_line_i;
            end else begin
              state_q        <= FILL;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_tag_i, index_i, 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp_i) begin
            state_q        <= FILL;
            pmem_write_q   <= 1'b0;
            pmem_read_q    <= 1'b1;
            pmem_address_q <= {req_tag_i, index_i, 4'b0000};
            pmem_wdata_q   <= '0;
          end
        end
        FILL: begin
          if (pmem_resp_i) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_address_q <= 16'h0000;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign idle_o         = (state_q == IDLE);
  assign load_line_o    = (state_q == FILL) && pmem_resp_i;
  assign pmem_read_o    = pmem_read_q;
  assign pmem_write_o   = pmem_write_q;
  assign pmem_address_o = pmem_address_q;
  assign pmem_wdata_o   = pmem_wdata_q;

endmodule

// File: rtl/l1_cache_responder.sv
// Direct-mapped, write-back, write-allocate L1 cache responder.
// Holds tag/data/valid/dirty arrays, tag compare, word select and byte merge;
// the miss path lives in l1_cache_control.
// Optional macro L1_CACHE_PERF_CTR_EN adds saturating hit_count/miss_count outputs.
module l1_cache_responder
  import lc3b_types::*;
#(
  parameter int NUM_SETS = C_NUM_SETS,
  parameter int TAG_W    = C_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp
`ifdef L1_CACHE_PERF_CTR_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);

  // Storage: tags and lines are never reset, only valid/dirty
  logic [TAG_W-1:0] tag_q  [NUM_SETS];
  lc3b_c_block      data_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] index;
  lc3b_c_offset     offset;
  logic             req;
  logic             is_write;
  logic             hit;
  logic             idle;
  logic             load_line;
  lc3b_c_block      line;
  lc3b_c_block      merged_line;
  logic [15:0]      words [8];
  logic [15:0]      sel_word;
  logic [15:0]      merged_word;
  logic             unused_addr_bit;

  // Byte address bit 0 does not participate in word selection
  assign unused_addr_bit = mem_address[0];

  assign req_tag  = mem_address[15 -: TAG_W];
  assign index    = mem_address[4 +: IDX_W];
  assign offset   = mem_address[3:1];
  assign req      = mem_read | mem_write;
  // A simultaneous read+write is handled as a read
  assign is_write = mem_write & ~mem_read;

  assign line = data_q[index];
  assign hit  = valid_q[index] && (tag_q[index] == req_tag);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign words[gi] = line[gi*16 +: 16];
      assign merged_line[gi*16 +: 16] = (offset == 3'(gi)) ? merged_word : words[gi];
    end
  endgenerate

  assign sel_word    = words[offset];
  assign merged_word = merge_word(sel_word, mem_wdata, mem_byte_enable);

  // Hits are answered combinationally, only while the controller is idle
  assign mem_resp  = idle && req && hit;
  assign mem_rdata = (mem_resp && !is_write) ? sel_word : 16'h0000;

  l1_cache_control #(
    .TAG_W(TAG_W),
    .IDX_W(IDX_W)
  ) u_control (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .hit_i          (hit),
    .victim_dirty_i (valid_q[index] & dirty_q[index]),
    .victim_tag_i   (tag_q[index]),
    .req_tag_i      (req_tag),
    .index_i        (index),
    .victim_line_i  (line),
    .pmem_resp_i    (pmem_resp),
    .idle_o         (idle),
    .load_line_o    (load_line),
    .pmem_read_o    (pmem_read),
    .pmem_write_o   (pmem_write),
    .pmem_address_o (pmem_address),
    .pmem_wdata_o   (pmem_wdata)
  );

  // Line/tag storage: fill from pmem, or merge a hit write into the line
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_q[index] <= pmem_rdata;
      tag_q[index]  <= req_tag;
    end else if (mem_resp && is_write && (mem_byte_enable != 2'b00)) begin
      data_q[index] <= merged_line;
    end
  end

  // Valid/dirty state: cleared on reset, set by fills and byte-enabled writes
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_line) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (mem_resp && is_write && (mem_byte_enable != 2'b00)) begin
      dirty_q[index] <= 1'b1;
    end
  end

`ifdef L1_CACHE_PERF_CTR_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        filled_q;

  // Saturating counters; the response that completes a miss is not a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
      filled_q     <= 1'b0;
    end else begin
      if (mem_resp && !filled_q && (hit_count_q != 16'hFFFF))
        hit_count_q <= hit_count_q + 16'd1;
      if (idle && req && !hit && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;
      if (load_line)
        filled_q <= 1'b1;
      else if (mem_resp)
        filled_q <= 1'b0;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_l1_cache_responder.sv
// Directed self-checking bench for l1_cache_responder (optionally with
// L1_CACHE_PERF_CTR_EN defined to exercise the performance counters).
module tb_l1_cache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
`ifdef L1_CACHE_PERF_CTR_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A  = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] LINE_AM = 128'h0007_0006_0005_0004_0003_BE34_0001_0000;
  localparam logic [127:0] LINE_B  = 128'h7777_6666_5555_4444_3333_2222_1111_0AAA;
  localparam logic [127:0] LINE_C  = 128'hC7C7_C6C6_C5C5_C4C4_C3C3_C2C2_C1C1_C0C0;

  always #5 clk = ~clk;

  l1_cache_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp)
`ifdef L1_CACHE_PERF_CTR_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Wait (bounded) until the DUT raises a pmem request
  task automatic wait_pmem(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pmem_read || pmem_write) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) check({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  // Answer the outstanding pmem request after lat cycles of it being asserted
  task automatic pmem_reply(input logic [127:0] data, input int lat);
    repeat (lat - 1) step();
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
  endtask

  // Single-cycle read expected to hit
  task automatic read_hit(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    mem_address = addr;
    mem_read    = 1'b1;
    #1;
    check({tag, "_resp"}, 128'(mem_resp), 128'd1);
    check({tag, "_rdata"}, 128'(mem_rdata), 128'(exp));
    step();
    idle_bus();
  endtask

  // Single-cycle write expected to hit
  task automatic write_hit(input string tag, input logic [15:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
    mem_address     = addr;
    mem_wdata       = data;
    mem_byte_enable = be;
    mem_write       = 1'b1;
    #1;
    check({tag, "_resp"}, 128'(mem_resp), 128'd1);
    check({tag, "_rdata0"}, 128'(mem_rdata), 128'd0);
    step();
    idle_bus();
    mem_byte_enable = 2'b11;
  endtask

  initial begin
    rst             = 1'b1;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b11;
    pmem_rdata      = '0;
    pmem_resp       = 1'b0;

    // Reset state
    step();
    step();
    #1;
    check("rst_mem_resp", 128'(mem_resp), 128'd0);
    check("rst_mem_rdata", 128'(mem_rdata), 128'd0);
    check("rst_pmem_read", 128'(pmem_read), 128'd0);
    check("rst_pmem_write", 128'(pmem_write), 128'd0);
    check("rst_pmem_addr", 128'(pmem_address), 128'd0);
    check("rst_pmem_wdata", pmem_wdata, 128'd0);
    step();
    rst = 1'b0;

    // 1: cold read miss at 0x0042, fill after 3 cycles
    mem_address = 16'h0042;
    mem_read    = 1'b1;
    #1;
    check("s1_miss_resp", 128'(mem_resp), 128'd0);
    step();
    wait_pmem("s1");
    check("s1_pmem_read", 128'(pmem_read), 128'd1);
    check("s1_pmem_write", 128'(pmem_write), 128'd0);
    check("s1_pmem_addr", 128'(pmem_address), 128'h0040);
    pmem_reply(LINE_A, 3);
    #1;
    check("s1_fill_resp", 128'(mem_resp), 128'd1);
    check("s1_fill_rdata", 128'(mem_rdata), 128'h0001);
    check("s1_fill_pread", 128'(pmem_read), 128'd0);
    step();
    idle_bus();
    #1;
    check("s1_idle_resp", 128'(mem_resp), 128'd0);
    step();
    read_hit("s1_hit0", 16'h0042, 16'h0001);
    read_hit("s1_hit1", 16'h004E, 16'h0007);
`ifdef L1_CACHE_PERF_CTR_EN
    check("perf_miss", 128'(miss_count), 128'd1);
    check("perf_hit", 128'(hit_count), 128'd2);
`endif

    // 2: write hits, full word then low byte, then a no-op byte enable
    write_hit("s2_w11", 16'h0044, 16'hBEEF, 2'b11);
    read_hit("s2_r11", 16'h0044, 16'hBEEF);
    write_hit("s2_w01", 16'h0044, 16'h1234, 2'b01);
    read_hit("s2_r01", 16'h0044, 16'hBE34);
    write_hit("s2_w00", 16'h0044, 16'hFFFF, 2'b00);
    read_hit("s2_r00", 16'h0044, 16'hBE34);
    check("s2_no_pread", 128'(pmem_read), 128'd0);
    check("s2_no_pwrite", 128'(pmem_write), 128'd0);

    // 3: dirty victim at index 4 evicted by 0x0840
    mem_address = 16'h0840;
    mem_read    = 1'b1;
    #1;
    check("s3_miss_resp", 128'(mem_resp), 128'd0);
    step();
    wait_pmem("s3wb");
    check("s3_pmem_write", 128'(pmem_write), 128'd1);
    check("s3_wb_pread", 128'(pmem_read), 128'd0);
    check("s3_wb_addr", 128'(pmem_address), 128'h0040);
    check("s3_wb_data", pmem_wdata, LINE_AM);
    pmem_reply(128'd0, 2);
    check("s3_fill_pread", 128'(pmem_read), 128'd1);
    check("s3_fill_pwrite", 128'(pmem_write), 128'd0);
    check("s3_fill_addr", 128'(pmem_address), 128'h0840);
    check("s3_fill_resp0", 128'(mem_resp), 128'd0);
    pmem_reply(LINE_B, 2);
    #1;
    check("s3_resp", 128'(mem_resp), 128'd1);
    check("s3_rdata", 128'(mem_rdata), 128'h0AAA);
    step();
    idle_bus();

    // 4: clean victim (0x0840 line) replaced by 0x004E
    mem_address = 16'h004E;
    mem_read    = 1'b1;
    step();
    wait_pmem("s4");
    check("s4_pmem_write", 128'(pmem_write), 128'd0);
    check("s4_pmem_read", 128'(pmem_read), 128'd1);
    check("s4_pmem_addr", 128'(pmem_address), 128'h0040);
    pmem_reply(LINE_A, 1);
    #1;
    check("s4_rdata", 128'(mem_rdata), 128'h0007);
    step();
    idle_bus();

    // Index wrap: 0xFFF0 uses the last set
    mem_address = 16'hFFF0;
    mem_read    = 1'b1;
    step();
    wait_pmem("wrap");
    check("wrap_addr", 128'(pmem_address), 128'hFFF0);
    pmem_reply(LINE_C, 2);
    #1;
    check("wrap_rdata", 128'(mem_rdata), 128'hC0C0);
    step();
    idle_bus();

    // 5: reset during FILL, late pmem_resp ignored
    mem_address = 16'h0100;
    mem_read    = 1'b1;
    step();
    wait_pmem("s5");
    check("s5_pmem_read", 128'(pmem_read), 128'd1);
    rst = 1'b1;
    idle_bus();
    step();
    rst = 1'b0;
    step();
    pmem_rdata = LINE_C;
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    #1;
    check("s5_pread_off", 128'(pmem_read), 128'd0);
    check("s5_addr_zero", 128'(pmem_address), 128'd0);
    step();
    mem_address = 16'h004E;
    mem_read    = 1'b1;
    #1;
    check("s5_inval_resp", 128'(mem_resp), 128'd0);
    idle_bus();
    step();
    // Any pmem request launched by the probe above is drained
    if (pmem_read) pmem_reply(LINE_A, 1);
    step();
    mem_address = 16'h0100;
    mem_read    = 1'b1;
    #1;
    check("s5_remiss_resp", 128'(mem_resp), 128'd0);
    step();
    wait_pmem("s5b");
    check("s5_re_pread", 128'(pmem_read), 128'd1);
    check("s5_re_addr", 128'(pmem_address), 128'h0100);
    pmem_reply(LINE_B, 2);
    #1;
    check("s5_re_rdata", 128'(mem_rdata), 128'h0AAA);
    step();
    idle_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
